// File: rtl/popcnt_accum.sv
// rtl/popcnt_accum.sv - per-frame popcount accumulator (optional parity: POPCNT_ACCUM_PARITY_EN)
module popcnt_accum #(
  parameter int WORDS = 8,
  parameter int SUM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_cnt,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [7:0]       out_words,
  output logic [5:0]       out_max,
  output logic             out_ovf,
  output logic             out_err
`ifdef POPCNT_ACCUM_PARITY_EN
  ,
  output logic             out_par
`endif
);

  typedef enum logic {S_ACC = 1'b0, S_HOLD = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [SUM_W-1:0] r_sum;
  logic [7:0]       r_words;
  logic [5:0]       r_max;
  logic             r_ovf;
  logic             r_err;

  logic [SUM_W-1:0] r_out_sum;
  logic [7:0]       r_out_words;
  logic [5:0]       r_out_max;
  logic             r_out_ovf;
  logic             r_out_err;

  logic             w_accept;
  logic             w_release;
  logic             w_frame_end;
  logic             w_cnt_bad;
  logic [5:0]       w_cnt;
  logic [SUM_W:0]   w_sum_wide;
  logic             w_sum_sat;
  logic [SUM_W-1:0] w_sum_nxt;
  logic [7:0]       w_words_nxt;
  logic [5:0]       w_max_nxt;
  logic             w_ovf_nxt;
  logic             w_err_nxt;

  // Handshakes decode straight from the state register so out_ready never reaches in_ready
  assign in_ready  = (r_state == S_ACC);
  assign out_valid = (r_state == S_HOLD);
  assign w_accept  = in_valid & in_ready;
  assign w_release = (r_state == S_HOLD) & out_ready;

  // Clamp the incoming count, then form the saturating running totals for this accept
  always_comb begin
    w_cnt_bad   = (in_cnt > 6'd32);
    w_cnt       = w_cnt_bad ? 6'd32 : in_cnt;
    w_sum_wide  = {1'b0, r_sum} + (SUM_W + 1)'(w_cnt);
    w_sum_sat   = w_sum_wide[SUM_W];
    w_sum_nxt   = w_sum_sat ? {SUM_W{1'b1}} : w_sum_wide[SUM_W-1:0];
    w_words_nxt = r_words + 8'd1;
    w_max_nxt   = (w_cnt > r_max) ? w_cnt : r_max;
    w_ovf_nxt   = r_ovf | w_sum_sat;
    w_err_nxt   = r_err | w_cnt_bad;
    // in_last and the word limit in the same accept still make only one frame end
    w_frame_end = w_accept & (in_last | (w_words_nxt == 8'(WORDS)));
  end

  // Next state: close a frame into HOLD, return to ACC once the consumer takes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACC:   if (w_frame_end) w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready)   w_state_nxt = S_ACC;
      default: w_state_nxt = S_ACC;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_ACC;
    else        r_state <= w_state_nxt;
  end

  // Running accumulators: fold in each accept, clear when the held frame is taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum   <= '0;
      r_words <= '0;
      r_max   <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_release) begin
      r_sum   <= '0;
      r_words <= '0;
      r_max   <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_sum   <= w_sum_nxt;
      r_words <= w_words_nxt;
      r_max   <= w_max_nxt;
      r_ovf   <= w_ovf_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Result registers: capture totals including the terminating word, hold until the next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_sum   <= '0;
      r_out_words <= '0;
      r_out_max   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_frame_end) begin
      r_out_sum   <= w_sum_nxt;
      r_out_words <= w_words_nxt;
      r_out_max   <= w_max_nxt;
      r_out_ovf   <= w_ovf_nxt;
      r_out_err   <= w_err_nxt;
    end
  end

  assign out_sum   = r_out_sum;
  assign out_words = r_out_words;
  assign out_max   = r_out_max;
  assign out_ovf   = r_out_ovf;
  assign out_err   = r_out_err;

`ifdef POPCNT_ACCUM_PARITY_EN
  logic r_par;
  logic r_out_par;
  logic w_par_nxt;

  // Parity of the unsaturated total is just the XOR of each clamped count's LSB
  assign w_par_nxt = r_par ^ w_cnt[0];

  // Parity accumulator and its result register, same clear/capture timing as the totals
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par     <= 1'b0;
      r_out_par <= 1'b0;
    end else begin
      if (w_release)     r_par <= 1'b0;
      else if (w_accept) r_par <= w_par_nxt;
      if (w_frame_end)   r_out_par <= w_par_nxt;
    end
  end

  assign out_par = r_out_par;
`endif

endmodule

// File: tb/tb_popcnt_accum.sv
// tb/tb_popcnt_accum.sv - directed table-driven bench for popcnt_accum
module tb_popcnt_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_last, out_ready;
  logic [5:0]  in_cnt;

  logic        in_ready, out_valid, out_ovf, out_err;
  logic [15:0] out_sum;
  logic [7:0]  out_words;
  logic [5:0]  out_max;

  logic        in_ready8, out_valid8, out_ovf8, out_err8;
  logic [7:0]  out_sum8, out_words8;
  logic [5:0]  out_max8;

  logic        v1, l1, ordy1;
  logic [5:0]  c1;
  logic        in_ready1, out_valid1, out_ovf1, out_err1;
  logic [15:0] out_sum1;
  logic [7:0]  out_words1;
  logic [5:0]  out_max1;

`ifdef POPCNT_ACCUM_PARITY_EN
  logic out_par, out_par8, out_par1;
`endif

  popcnt_accum #(.WORDS(8), .SUM_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cnt(in_cnt), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_words(out_words), .out_max(out_max),
    .out_ovf(out_ovf), .out_err(out_err)
`ifdef POPCNT_ACCUM_PARITY_EN
    , .out_par(out_par)
`endif
  );

  popcnt_accum #(.WORDS(8), .SUM_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .in_cnt(in_cnt), .in_last(in_last), .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(out_sum8), .out_words(out_words8), .out_max(out_max8),
    .out_ovf(out_ovf8), .out_err(out_err8)
`ifdef POPCNT_ACCUM_PARITY_EN
    , .out_par(out_par8)
`endif
  );

  popcnt_accum #(.WORDS(1), .SUM_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(in_ready1),
    .in_cnt(c1), .in_last(l1), .out_valid(out_valid1), .out_ready(ordy1),
    .out_sum(out_sum1), .out_words(out_words1), .out_max(out_max1),
    .out_ovf(out_ovf1), .out_err(out_err1)
`ifdef POPCNT_ACCUM_PARITY_EN
    , .out_par(out_par1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int               n;
    logic [7:0][5:0]  cnt;
    bit               last;
    int               sum;
    int               words;
    int               max;
    bit               ovf;
    bit               err;
    int               sum8;
    bit               ovf8;
    bit               par;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [47:0] c, input bit last,
                              input int s, input int w, input int m, input bit o,
                              input bit e, input int s8, input bit o8, input bit p);
    vec_t v;
    v.n = n; v.cnt = c; v.last = last; v.sum = s; v.words = w; v.max = m;
    v.ovf = o; v.err = e; v.sum8 = s8; v.ovf8 = o8; v.par = p;
    return v;
  endfunction

  // Present one word and wait (bounded) for it to be accepted; returns at a negedge
  task automatic send(input logic [5:0] cnt, input logic last);
    int k;
    in_valid = 1'b1; in_cnt = cnt; in_last = last;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=0 expected=1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Complete the output handshake and confirm the bubble ends with in_ready high
  task automatic take_result(input int held_sum);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_take_out_valid", 32'(out_valid), 0);
    chk("after_take_in_ready", 32'(in_ready), 1);
    chk("after_take_sum_held", 32'(out_sum), held_sum);
  endtask

  vec_t vecs[7];
  logic [15:0] hold_sum;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(8, {8{6'd32}}, 1'b0, 256, 8, 32, 0, 0, 255, 1, 0);
    vecs[1] = mk(3, 48'({6'd17, 6'd0, 6'd3}), 1'b1, 20, 3, 17, 0, 0, 20, 0, 0);
    vecs[2] = mk(1, 48'(6'd45), 1'b1, 32, 1, 32, 0, 1, 32, 0, 0);
    vecs[3] = mk(3, 48'({6'd3, 6'd2, 6'd1}), 1'b1, 6, 3, 3, 0, 0, 6, 0, 0);
    vecs[4] = mk(8, {8{6'd1}}, 1'b1, 8, 8, 1, 0, 0, 8, 0, 0);
    vecs[5] = mk(2, 48'({6'd63, 6'd33}), 1'b1, 64, 2, 32, 0, 1, 64, 0, 0);
    vecs[6] = mk(1, 48'(6'd5), 1'b1, 5, 1, 5, 0, 0, 5, 0, 1);

    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_cnt = '0; out_ready = 1'b0;
    v1 = 1'b0; l1 = 1'b0; c1 = '0; ordy1 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_words", 32'(out_words), 0);
    chk("rst_out_max", 32'(out_max), 0);
    chk("rst_out_flags", 32'({out_ovf, out_err}), 0);

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < vecs[t].n; i++)
        send(vecs[t].cnt[i], (i == vecs[t].n - 1) ? vecs[t].last : 1'b0);
      chk($sformatf("v%0d_out_valid", t), 32'(out_valid), 1);
      chk($sformatf("v%0d_in_ready", t), 32'(in_ready), 0);
      chk($sformatf("v%0d_sum", t), 32'(out_sum), vecs[t].sum);
      chk($sformatf("v%0d_words", t), 32'(out_words), vecs[t].words);
      chk($sformatf("v%0d_max", t), 32'(out_max), vecs[t].max);
      chk($sformatf("v%0d_ovf", t), 32'(out_ovf), 32'(vecs[t].ovf));
      chk($sformatf("v%0d_err", t), 32'(out_err), 32'(vecs[t].err));
      chk($sformatf("v%0d_sum8", t), 32'(out_sum8), vecs[t].sum8);
      chk($sformatf("v%0d_ovf8", t), 32'(out_ovf8), 32'(vecs[t].ovf8));
`ifdef POPCNT_ACCUM_PARITY_EN
      chk($sformatf("v%0d_par", t), 32'(out_par), 32'(vecs[t].par));
`endif
      take_result(vecs[t].sum);
    end

    // Back-pressure: a pending word must wait through HOLD and start the next frame
    send(6'd7, 1'b0);
    send(6'd9, 1'b1);
    in_valid = 1'b1; in_cnt = 6'd11; in_last = 1'b1;
    hold_sum = out_sum;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_out_sum", 32'(out_sum), 16);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_release_in_ready", 32'(in_ready), 1);
    chk("hold_release_sum_kept", 32'(out_sum), 32'(hold_sum));
    send(6'd11, 1'b1);
    chk("after_hold_valid", 32'(out_valid), 1);
    chk("after_hold_sum", 32'(out_sum), 11);
    chk("after_hold_words", 32'(out_words), 1);
    chk("after_hold_max", 32'(out_max), 11);
    take_result(11);

    // Asynchronous reset mid-frame discards the partial frame
    for (int i = 0; i < 4; i++) send(6'd1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_sum", 32'(out_sum), 0);
    chk("midrst_out_words", 32'(out_words), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 1);
    send(6'd4, 1'b0);
    send(6'd6, 1'b1);
    chk("postrst_valid", 32'(out_valid), 1);
    chk("postrst_words", 32'(out_words), 2);
    chk("postrst_sum", 32'(out_sum), 10);
    chk("postrst_max", 32'(out_max), 6);
    take_result(10);

    // WORDS=1: every accept closes a frame without in_last
    for (int k = 0; k < 2; k++) begin
      c1 = (k == 0) ? 6'd4 : 6'd40;
      v1 = 1'b1;
      chk("w1_in_ready", 32'(in_ready1), 1);
      @(negedge clk);
      v1 = 1'b0;
      chk("w1_out_valid", 32'(out_valid1), 1);
      chk("w1_in_ready_hold", 32'(in_ready1), 0);
      chk("w1_sum", 32'(out_sum1), (k == 0) ? 4 : 32);
      chk("w1_words", 32'(out_words1), 1);
      chk("w1_err", 32'(out_err1), (k == 0) ? 0 : 1);
      @(negedge clk);
      chk("w1_released", 32'(out_valid1), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
